csr_timer_irq: RTL and testbench
================================

Name: csr_timer_irq

Overview:
Parametrised timer and interrupt-status CSR unit. It takes over TID, TCFG, TVAL, TICLR, ECFG and ESTAT.IS from the monolithic CSR file. It adds input synchronisers, a one-shot mode that halts correctly, and a registered interrupt request. It sits beside the main CSR file in the WB stage; that file ORs csr_rvalue into its read mux when csr_hit is high.

Parameters:
TIMER_W, 32, counter width; legal range 8..32. TCFG.InitVal occupies bits [TIMER_W-1:2].
HW_INT_N, 8, number of hardware interrupt lines (1..8), mapped to IS[2+HW_INT_N-1:2].
SYNC_STAGES, 2, synchroniser depth for hw_int_in and ipi_int_in (>=2).
CORE_ID, 0, 32-bit reset value of TID.

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous, active-low reset
csr_we  in  1  CSR write strobe
csr_num  in  14  CSR address
csr_wmask  in  32  write bit mask
csr_wvalue  in  32  write data
csr_rvalue  out  32  read data for owned CSRs; 0 otherwise
csr_hit  out  1  csr_num is one of 0x04, 0x05, 0x40, 0x41, 0x42, 0x44
crmd_ie  in  1  global interrupt enable, CRMD.IE
hw_int_in  in  HW_INT_N  asynchronous level interrupts
ipi_int_in  in  1  asynchronous inter-processor interrupt
has_int  out  1  registered interrupt request to the pipeline
timer_int  out  1  current IS[11] (TI)

Behaviour:
- Reset (async, resetn=0). TID=CORE_ID; TCFG.En=0, Periodic=0, InitVal=0. Counter=all-ones; running=0. IS=0, LIE=0, all synchroniser flops=0. has_int=0.
- All writes use masked merge: new = wmask&wvalue | ~wmask&old. Writes take effect at the next clk edge.
- Read mux is combinational.
  - ECFG returns {19'b0, LIE}.
  - ESTAT returns {19'b0, IS}.
  - TCFG returns {zero-extend, InitVal, Periodic, En}.
  - TVAL returns the counter, zero-extended.
  - TICLR always reads 0.
- ECFG: LIE[12:0] is writable except bit 10, which is forced to 0 (effective mask 0x1BFF).
- ESTAT: only IS[1:0] (SWI) are software-writable. All other ESTAT writes are ignored.
- IS[2+k] is the SYNC_STAGES-deep synchronised hw_int_in[k]. It is level-sensitive and has no latching. IS bits above 2+HW_INT_N-1 up to bit 9 read 0.
- IS[12] is the synchronised ipi_int_in.
- IS[10] is always 0.
- Counter, TCFG write (priority 1):
  - The merged value with En=1 loads the counter with {InitVal,2'b00} and sets running=1.
  - The merged value with En=0 clears running and leaves the counter frozen.
- Counter, otherwise, while En=1 and running=1:
  - If counter==0: expiry event.
    - Periodic=1: reload {InitVal,2'b00}; running stays 1.
    - Periodic=0: counter <= all-ones; running=0.
  - Else: counter <= counter-1.
- Timer behaviour in the stopped state:
  - The counter never decrements from all-ones while running=0, so a one-shot timer fires exactly once.
  - Periodic with InitVal=0 produces an expiry every cycle.
- TI (IS[11]) set/clear:
  - Set on an expiry event.
  - Cleared by a TICLR write with wmask[0]&wvalue[0]=1.
  - Same-cycle expiry and clear: set wins.
- has_int (flop): next = crmd_ie & |(IS & LIE). Latency is one cycle after an IS/LIE/crmd_ie change is visible.
- A TID write updates all 32 bits under the mask.
- Unowned csr_num: writes are ignored; csr_rvalue=0, csr_hit=0.
- Reset asserted mid-countdown returns every register to its reset value immediately. Nothing resumes after resetn rises.

Test Plan:
1. Write TCFG=0x0000_0011 (InitVal=4, one-shot, En). Then:
   - TVAL reads 0x10,0x0F,…,0 on successive cycles.
   - The next cycle TVAL=0xFFFF_FFFF and TI=1.
   - TVAL stays 0xFFFF_FFFF and TI is not re-set after a TICLR.
2. Write TCFG=0x0000_0007 (InitVal=1, periodic, En). TI is set every 5 cycles and TVAL cycles 4,3,2,1,0,4. Write TICLR=1 on an expiry cycle: TI remains 1.
3. Write ECFG=0x1FFF: reads 0x1BFF. Write ESTAT wvalue=0xFFFF, wmask=0xFFFF: only IS[1:0]=3. Set crmd_ie=1: has_int=1 exactly one cycle after the IS write.
4. HW_INT_N=4, SYNC_STAGES=2, pulse hw_int_in[3] high:
   - IS[5] rises 2 cycles later.
   - With LIE[5]=1 and crmd_ie=1, has_int rises 3 cycles after the input.
   - IS[9:6] stay 0.
5. CORE_ID=0x5, TIMER_W=16:
   - TID reads 5 after reset.
   - TCFG write 0xFFFF_FFFF reads 0x0000_FFFF.
   - TVAL reads 0xFFFC next cycle.
6. Assert resetn=0 asynchronously mid-countdown: all outputs return to reset values within that cycle, before the next clk edge. TVAL=0xFFFF_FFFF (TIMER_W=32) and has_int=0.

Source files
------------

// File: rtl/csr_timer_irq_if.sv
// csr_timer_irq_if: CSR access bus between the WB-stage CSR file (master) and csr_timer_irq (slave).
//   csr_we/csr_num/csr_wmask/csr_wvalue : write strobe, address, bit mask, data (master -> slave)
//   csr_rvalue/csr_hit                  : combinational read data and ownership flag (slave -> master)
interface csr_timer_irq_if;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [31:0] csr_rvalue;
  logic        csr_hit;
  modport master (output csr_we, csr_num, csr_wmask, csr_wvalue, input csr_rvalue, csr_hit);
  modport slave (input csr_we, csr_num, csr_wmask, csr_wvalue, output csr_rvalue, csr_hit);
endinterface

// File: rtl/csr_timer_irq.sv
// csr_timer_irq: timer (TID/TCFG/TVAL/TICLR) and interrupt status/enable (ESTAT.IS/ECFG) CSR unit.
//   clk, resetn : core clock, asynchronous active-low reset
//   csr         : CSR bus slave; reads are combinational, writes are masked merges at the next edge
//   crmd_ie     : global interrupt enable
//   hw_int_in   : asynchronous level interrupts, synchronised into IS[2+HW_INT_N-1:2]
//   ipi_int_in  : asynchronous inter-processor interrupt, synchronised into IS[12]
//   has_int     : registered interrupt request
//   timer_int   : timer interrupt status IS[11]
module csr_timer_irq #(
  parameter int          TIMER_W     = 32,
  parameter int          HW_INT_N    = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] CORE_ID     = 32'h0
) (
  input  logic                clk,
  input  logic                resetn,
  csr_timer_irq_if.slave      csr,
  input  logic                crmd_ie,
  input  logic [HW_INT_N-1:0] hw_int_in,
  input  logic                ipi_int_in,
  output logic                has_int,
  output logic                timer_int
);
  localparam logic [13:0] A_ECFG  = 14'h04;
  localparam logic [13:0] A_ESTAT = 14'h05;
  localparam logic [13:0] A_TID   = 14'h40;
  localparam logic [13:0] A_TCFG  = 14'h41;
  localparam logic [13:0] A_TVAL  = 14'h42;
  localparam logic [13:0] A_TICLR = 14'h44;
  logic [HW_INT_N:0]  sync_q [SYNC_STAGES];
  logic [12:0]        lie, is_v;
  logic [1:0]         swi;
  logic               ti, running, expire;
  logic [31:0]        tid, wm, wv;
  logic [TIMER_W-1:0] tcfg, tcfg_new, cnt;
  logic               we_ecfg, we_estat, we_tid, we_tcfg, we_ticlr;
  assign wm = csr.csr_wmask;
  assign wv = csr.csr_wvalue;
  assign we_ecfg  = csr.csr_we && csr.csr_num == A_ECFG;
  assign we_estat = csr.csr_we && csr.csr_num == A_ESTAT;
  assign we_tid   = csr.csr_we && csr.csr_num == A_TID;
  assign we_tcfg  = csr.csr_we && csr.csr_num == A_TCFG;
  assign we_ticlr = csr.csr_we && csr.csr_num == A_TICLR;
  assign tcfg_new = (wm[TIMER_W-1:0] & wv[TIMER_W-1:0]) | (~wm[TIMER_W-1:0] & tcfg);
  // A TCFG write takes priority, so an expiry cannot coincide with a reload by software.
  assign expire = !we_tcfg && tcfg[0] && running && cnt == '0;
  always_comb begin
    is_v = '0;
    is_v[1:0] = swi;
    is_v[2 +: HW_INT_N] = sync_q[SYNC_STAGES-1][HW_INT_N-1:0];
    is_v[11] = ti;
    is_v[12] = sync_q[SYNC_STAGES-1][HW_INT_N];
  end
  assign csr.csr_rvalue = csr.csr_num == A_ECFG  ? {19'b0, lie} :
                          csr.csr_num == A_ESTAT ? {19'b0, is_v} :
                          csr.csr_num == A_TID   ? tid :
                          csr.csr_num == A_TCFG  ? 32'(tcfg) :
                          csr.csr_num == A_TVAL  ? 32'(cnt) : '0;
  assign csr.csr_hit = csr.csr_num inside {A_ECFG, A_ESTAT, A_TID, A_TCFG, A_TVAL, A_TICLR};
  assign timer_int = ti;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      lie     <= '0;
      swi     <= '0;
      ti      <= 1'b0;
      tid     <= CORE_ID;
      tcfg    <= '0;
      cnt     <= '1;
      running <= 1'b0;
      has_int <= 1'b0;
    end else begin
      sync_q[0] <= {ipi_int_in, hw_int_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      if (we_ecfg) lie <= ((wm[12:0] & wv[12:0]) | (~wm[12:0] & lie)) & 13'h1BFF;
      if (we_estat) swi <= (wm[1:0] & wv[1:0]) | (~wm[1:0] & swi);
      if (we_tid) tid <= (wm & wv) | (~wm & tid);
      if (we_tcfg) tcfg <= tcfg_new;
      if (we_tcfg) begin
        running <= tcfg_new[0];
        cnt     <= tcfg_new[0] ? {tcfg_new[TIMER_W-1:2], 2'b00} : cnt;
      end else if (tcfg[0] && running) begin
        // One-shot expiry parks at all-ones with running cleared, so it never fires again.
        running <= cnt != '0 || tcfg[1];
        cnt     <= cnt != '0 ? cnt - TIMER_W'(1) : tcfg[1] ? {tcfg[TIMER_W-1:2], 2'b00} : '1;
      end
      ti      <= expire | (ti & ~(we_ticlr & wm[0] & wv[0]));
      has_int <= crmd_ie & |(is_v & lie);
    end
  end
endmodule

// File: tb/tb_csr_timer_irq.sv
// tb_csr_timer_irq: directed plus randomized checks of two csr_timer_irq instances against a closed-form model.
module tb_csr_timer_irq;
  localparam logic [13:0] ECFG = 14'h04, ESTAT = 14'h05, TID = 14'h40, TCFG = 14'h41, TVAL = 14'h42, TICLR = 14'h44;
  logic        clk = 1'b0;
  logic        resetn, we, crmd_ie, ipi;
  logic [13:0] num;
  logic [31:0] wmask, wvalue, r0, r1;
  logic [7:0]  hw;
  logic        hi0, hi1, ti0, ti1;
  int          total = 0, bad = 0;
  longint      e = 0;
  logic [12:0] lie_m;
  logic [1:0]  swi_m;
  logic [31:0] tid0_m, tid1_m;
  csr_timer_irq_if b0 ();
  csr_timer_irq_if b1 ();
  assign b0.csr_we = we;
  assign b0.csr_num = num;
  assign b0.csr_wmask = wmask;
  assign b0.csr_wvalue = wvalue;
  assign b1.csr_we = we;
  assign b1.csr_num = num;
  assign b1.csr_wmask = wmask;
  assign b1.csr_wvalue = wvalue;
  csr_timer_irq dut0 (.clk(clk), .resetn(resetn), .csr(b0.slave), .crmd_ie(crmd_ie), .hw_int_in(hw),
                      .ipi_int_in(ipi), .has_int(hi0), .timer_int(ti0));
  csr_timer_irq #(.TIMER_W(16), .HW_INT_N(4), .SYNC_STAGES(2), .CORE_ID(32'h5)) dut1 (
    .clk(clk), .resetn(resetn), .csr(b1.slave), .crmd_ie(crmd_ie), .hw_int_in(hw[3:0]),
    .ipi_int_in(ipi), .has_int(hi1), .timer_int(ti1));
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  // Expected TVAL e cycles after a load of value l: periodic wraps every l+1 cycles, one-shot parks at all-ones.
  function automatic logic [31:0] tv(input longint l, input bit per, input longint el, input int w);
    if (per) return 32'(l - el % (l + 1));
    return el <= l ? 32'(l - el) : 32'((64'd1 << w) - 1);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(negedge clk);
    e++;
  endtask
  task automatic wr(input logic [13:0] a, input logic [31:0] m, input logic [31:0] v);
    we = 1'b1; num = a; wmask = m; wvalue = v;
    step();
    we = 1'b0;
  endtask
  task automatic rd(input logic [13:0] a);
    num = a;
    #1;
    r0 = b0.csr_rvalue;
    r1 = b1.csr_rvalue;
  endtask
  task automatic chk_timer(input longint l0, input longint l1, input bit per, input bit cleared);
    rd(TVAL);
    chk("tval0", r0, tv(l0, per, e, 32));
    chk("tval1", r1, tv(l1, per, e, 16));
    chk("ti0", {31'b0, ti0}, {31'b0, !cleared && e > l0});
    chk("ti1", {31'b0, ti1}, {31'b0, !cleared && e > l1});
  endtask
  initial begin
    resetn = 1'b0; we = 1'b0; num = '0; wmask = '0; wvalue = '0; crmd_ie = 1'b0; hw = '0; ipi = 1'b0;
    repeat (2) @(negedge clk);
    rd(TVAL);  chk("rst_tval0", r0, 32'hFFFF_FFFF); chk("rst_tval1", r1, 32'h0000_FFFF);
    rd(TID);   chk("rst_tid0", r0, 32'h0); chk("rst_tid1", r1, 32'h5);
    rd(TCFG);  chk("rst_tcfg0", r0, 32'h0);
    rd(ESTAT); chk("rst_estat0", r0, 32'h0);
    rd(ECFG);  chk("rst_ecfg0", r0, 32'h0);
    chk("rst_has_int0", {31'b0, hi0}, 32'h0);
    resetn = 1'b1;
    step();
    // one-shot, InitVal=4
    wr(TCFG, '1, 32'h11);
    e = 0;
    rd(TCFG); chk("tcfg_rd0", r0, 32'h11);
    for (int i = 0; i < 20; i++) begin
      chk_timer(16, 16, 1'b0, 1'b0);
      step();
    end
    wr(TICLR, 32'h1, 32'h1);
    for (int i = 0; i < 5; i++) begin
      chk_timer(16, 16, 1'b0, 1'b1);
      step();
    end
    // periodic, InitVal=1
    wr(TCFG, '1, 32'h7);
    e = 0;
    for (int i = 0; i < 12; i++) begin
      chk_timer(4, 4, 1'b1, 1'b0);
      step();
    end
    while (e % 5 != 0) step();
    wr(TICLR, 32'h1, 32'h1);
    chk("ticlr_plain", {31'b0, ti0}, 32'h0);
    while (e % 5 != 4) step();
    wr(TICLR, 32'h1, 32'h1);
    chk("ticlr_vs_expiry0", {31'b0, ti0}, 32'h1);
    chk("ticlr_vs_expiry1", {31'b0, ti1}, 32'h1);
    // random reloads, including periodic with InitVal=0
    for (int t = 0; t < 20; t++) begin
      longint l;
      bit per;
      l = 4 * longint'($urandom_range(0, 6));
      per = 1'($urandom_range(0, 1));
      wr(TCFG, '1, 32'h0);
      wr(TICLR, 32'h1, 32'h1);
      wr(TCFG, '1, 32'(l) | {30'b0, per, 1'b1});
      e = 0;
      for (int k = $urandom_range(0, 30); k >= 0; k--) begin
        chk_timer(l, l, per, 1'b0);
        step();
      end
    end
    wr(TCFG, '1, 32'h0);
    wr(TICLR, 32'h1, 32'h1);
    // ECFG masking, SWI-only ESTAT writes, has_int latency
    crmd_ie = 1'b1;
    wr(ECFG, '1, 32'h1FFF);
    rd(ECFG); chk("ecfg_mask", r0, 32'h1BFF);
    chk("has_int_pre", {31'b0, hi0}, 32'h0);
    wr(ESTAT, 32'hFFFF, 32'hFFFF);
    rd(ESTAT); chk("estat_swi0", r0, 32'h3); chk("estat_swi1", r1, 32'h3);
    chk("has_int_not_yet", {31'b0, hi0}, 32'h0);
    step();
    chk("has_int_lat", {31'b0, hi0}, 32'h1);
    // random masked writes to owned and unowned CSRs
    lie_m = 13'h1BFF; swi_m = 2'b11; tid0_m = 32'h0; tid1_m = 32'h5;
    for (int t = 0; t < 30; t++) begin
      logic [31:0] m, v;
      logic [13:0] a;
      int s;
      m = $urandom; v = $urandom; s = $urandom_range(0, 4);
      a = s == 0 ? ECFG : s == 1 ? ESTAT : s == 2 ? TID : s == 3 ? 14'h123 : TICLR;
      crmd_ie = 1'($urandom_range(0, 1));
      if (a == ECFG) lie_m = 13'((m & v | ~m & {19'b0, lie_m}) & 32'h1BFF);
      if (a == ESTAT) swi_m = 2'((m & v | ~m & {30'b0, swi_m}) & 32'h3);
      if (a == TID) begin
        tid0_m = m & v | ~m & tid0_m;
        tid1_m = m & v | ~m & tid1_m;
      end
      wr(a, m, v);
      rd(ECFG);  chk("r_ecfg", r0, {19'b0, lie_m});
      rd(ESTAT); chk("r_estat", r0, {30'b0, swi_m});
      rd(TID);   chk("r_tid0", r0, tid0_m); chk("r_tid1", r1, tid1_m);
      rd(14'h123);
      chk("r_unowned", r0, 32'h0);
      chk("r_unowned_hit", {31'b0, b0.csr_hit}, 32'h0);
      step();
      chk("r_has_int", {31'b0, hi0}, {31'b0, crmd_ie && (lie_m[1:0] & swi_m) != 0});
    end
    rd(TICLR); chk("ticlr_reads0", r0, 32'h0); chk("ticlr_hit", {31'b0, b0.csr_hit}, 32'h1);
    // synchronised hardware interrupts and IPI
    wr(ECFG, '1, 32'h20);
    wr(ESTAT, 32'h3, 32'h0);
    crmd_ie = 1'b1;
    step(); step();
    chk("hw_pre_has_int", {31'b0, hi1}, 32'h0);
    hw = 8'hF8; ipi = 1'b1;
    step();
    rd(ESTAT); chk("hw_1cyc0", r0, 32'h0); chk("hw_1cyc1", r1, 32'h0);
    step();
    rd(ESTAT); chk("hw_2cyc0", r0, 32'h13E0); chk("hw_2cyc1", r1, 32'h1020);
    chk("hw_has_int_2", {31'b0, hi1}, 32'h0);
    step();
    chk("hw_has_int_3_0", {31'b0, hi0}, 32'h1);
    chk("hw_has_int_3_1", {31'b0, hi1}, 32'h1);
    hw = 8'h0; ipi = 1'b0;
    step(); step();
    rd(ESTAT); chk("hw_fall0", r0, 32'h0); chk("hw_fall1", r1, 32'h0);
    step();
    chk("hw_fall_has_int", {31'b0, hi1}, 32'h0);
    // width-truncated TCFG, then asynchronous reset mid-countdown
    wr(TCFG, '1, '1);
    e = 0;
    rd(TCFG); chk("tcfg_ff0", r0, 32'hFFFF_FFFF); chk("tcfg_ff1", r1, 32'h0000_FFFF);
    for (int i = 0; i < 3; i++) begin
      chk_timer(64'hFFFF_FFFC, 64'hFFFC, 1'b1, 1'b0);
      step();
    end
    wr(ECFG, '1, 32'h1);
    wr(ESTAT, 32'h3, 32'h1);
    step();
    chk("pre_rst_has_int", {31'b0, hi0}, 32'h1);
    chk_timer(64'hFFFF_FFFC, 64'hFFFC, 1'b1, 1'b0);
    #2 resetn = 1'b0;
    #1;
    chk("arst_has_int0", {31'b0, hi0}, 32'h0);
    rd(TVAL);  chk("arst_tval0", r0, 32'hFFFF_FFFF); chk("arst_tval1", r1, 32'h0000_FFFF);
    rd(TCFG);  chk("arst_tcfg0", r0, 32'h0);
    rd(ESTAT); chk("arst_estat0", r0, 32'h0);
    rd(TID);   chk("arst_tid0", r0, 32'h0); chk("arst_tid1", r1, 32'h5);
    @(negedge clk);
    resetn = 1'b1;
    step(); step(); step();
    rd(TVAL); chk("post_rst_tval0", r0, 32'hFFFF_FFFF); chk("post_rst_tval1", r1, 32'h0000_FFFF);
    chk("post_rst_has_int", {31'b0, hi0}, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
